// File: rtl/tcam_pkg.sv
// Shared definitions for the TCAM match sequencer: state encoding and default geometry.
package tcam_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int ADDRESS_SIZE = 4;
    localparam int ENTRIES      = 1 << ADDRESS_SIZE;

endpackage

// File: rtl/tcam_match_sequencer_if.sv
// Bitmap-in / address-out stream bundle between the CAM, the sequencer and the action stage.
interface tcam_match_sequencer_if #(
    parameter int address_size = 4
);
    logic [(1<<address_size)-1:0] matched;
    logic                         match_valid;
    logic                         match_ready;
    logic [address_size-1:0]      address;
    logic                         valid;
    logic                         ready;
    logic                         last;
    logic                         miss;
    logic [address_size:0]        count;

    // master: CAM/result-stage side; slave: the sequencer itself
    modport master (
        output matched, match_valid, ready,
        input  match_ready, address, valid, last, miss, count
    );

    modport slave (
        input  matched, match_valid, ready,
        output match_ready, address, valid, last, miss, count
    );
endinterface

// File: rtl/lowest_set_bit_encoder.sv
// Combinational priority encoder: isolates the lowest set bit of a bitmap and returns its index.
module lowest_set_bit_encoder #(
    parameter int address_size = 4
) (
    input  logic [(1<<address_size)-1:0] i_bitmap,
    output logic [address_size-1:0]      o_index,
    output logic [(1<<address_size)-1:0] o_onehot,
    output logic                         o_any
);
    localparam int ENTRIES = 1 << address_size;

    // x & -x keeps only the lowest set bit; zero bitmap gives zero onehot and index 0
    assign o_onehot = i_bitmap & (~i_bitmap + ENTRIES'(1));
    assign o_any    = |i_bitmap;

    for (genvar gi = 0; gi < address_size; gi++) begin : g_index_bit
        logic [ENTRIES-1:0] w_mask;
        for (genvar gj = 0; gj < ENTRIES; gj++) begin : g_mask
            assign w_mask[gj] = (((gj >> gi) & 1) != 0);
        end
        assign o_index[gi] = |(o_onehot & w_mask);
    end
endmodule

// File: rtl/tcam_match_sequencer.sv
// Captures one CAM match bitmap per lookup and streams the matching entry indices, lowest first.
module tcam_match_sequencer
    import tcam_pkg::*;
#(
    parameter int address_size = ADDRESS_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,
    tcam_match_sequencer_if.slave bus
);
    localparam int N_ENTRIES = 1 << address_size;

    state_t                  r_state;
    logic [N_ENTRIES-1:0]    r_pending;
    logic [address_size:0]   r_count;
    logic                    r_miss;

    logic [address_size-1:0] w_index;
    logic [N_ENTRIES-1:0]    w_onehot;
    logic                    w_any;
    logic                    w_last;
    logic [address_size:0]   w_popcount;

    lowest_set_bit_encoder #(
        .address_size(address_size)
    ) u_lsb (
        .i_bitmap(r_pending),
        .o_index (w_index),
        .o_onehot(w_onehot),
        .o_any   (w_any)
    );

    // exactly one bit set: non-empty and clearing the lowest bit leaves nothing
    assign w_last = w_any && ((r_pending & (r_pending - N_ENTRIES'(1))) == '0);

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < N_ENTRIES; i++) begin
            w_popcount = w_popcount + (address_size+1)'(bus.matched[i]);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_count   <= '0;
            r_miss    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.match_valid) begin
                        r_pending <= bus.matched;
                        r_count   <= w_popcount;
                        r_miss    <= (bus.matched == '0);
                        if (bus.matched != '0) r_state <= BUSY;
                    end else begin
                        r_miss <= 1'b0;
                    end
                end
                BUSY: begin
                    // new bitmaps are dropped here; upstream is gated by match_ready
                    r_miss <= 1'b0;
                    if (bus.ready) begin
                        r_pending <= r_pending & ~w_onehot;
                        if (w_last) r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.match_ready = (r_state == IDLE);
    assign bus.valid       = (r_state == BUSY);
    assign bus.address     = w_index;
    assign bus.last        = w_last;
    assign bus.miss        = r_miss;
    assign bus.count       = r_count;
endmodule

// File: tb/tb_tcam_match_sequencer.sv
// Directed bench for tcam_match_sequencer: inputs change and outputs are sampled on the falling edge.
`timescale 1ns/1ps
module tb_tcam_match_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tcam_match_sequencer_if #(.address_size(4)) bus ();

    tcam_match_sequencer #(.address_size(4)) dut (
        .clock(clk),
        .reset(rst),
        .bus  (bus)
    );

    task automatic idle_inputs();
        bus.matched     = 16'h0000;
        bus.match_valid = 1'b0;
        bus.ready       = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.match_ready, bus.valid, bus.last, bus.address, bus.count, bus.miss} !==
            {1'b1, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy/vld/last/addr/cnt/miss got %b/%b/%b/%0d/%0d/%b required 1/0/0/0/0/0",
                     bus.match_ready, bus.valid, bus.last, bus.address, bus.count, bus.miss);
        end
        $display("reset: match_ready=%b valid=%b count=%0d", bus.match_ready, bus.valid, bus.count);
    endtask

    task automatic test_two_match();
        bus.matched = 16'h0012; bus.match_valid = 1'b1; bus.ready = 1'b1;
        @(negedge clk);
        bus.match_valid = 1'b0;
        n_cmp++;
        if ({bus.valid, bus.address, bus.last, bus.count, bus.match_ready} !== {1'b1, 4'd1, 1'b0, 5'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL two_first: vld/addr/last/cnt/rdy got %b/%0d/%b/%0d/%b required 1/1/0/2/0",
                     bus.valid, bus.address, bus.last, bus.count, bus.match_ready);
        end
        $display("two_match beat: address=%0d last=%b", bus.address, bus.last);
        @(negedge clk);
        n_cmp++;
        if ({bus.valid, bus.address, bus.last} !== {1'b1, 4'd4, 1'b1}) begin
            n_fail++;
            $display("FAIL two_second: vld/addr/last got %b/%0d/%b required 1/4/1", bus.valid, bus.address, bus.last);
        end
        $display("two_match beat: address=%0d last=%b", bus.address, bus.last);
        @(negedge clk);
        n_cmp++;
        if ({bus.valid, bus.match_ready, bus.last, bus.address} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
            n_fail++;
            $display("FAIL two_done: vld/rdy/last/addr got %b/%b/%b/%0d required 0/1/0/0",
                     bus.valid, bus.match_ready, bus.last, bus.address);
        end
        $display("two_match done: match_ready=%b", bus.match_ready);
    endtask

    task automatic test_miss();
        bus.matched = 16'h0000; bus.match_valid = 1'b1;
        @(negedge clk);
        bus.match_valid = 1'b0;
        n_cmp++;
        if ({bus.miss, bus.count, bus.valid, bus.match_ready} !== {1'b1, 5'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL miss_pulse: miss/cnt/vld/rdy got %b/%0d/%b/%b required 1/0/0/1",
                     bus.miss, bus.count, bus.valid, bus.match_ready);
        end
        $display("miss lookup: miss=%b count=%0d", bus.miss, bus.count);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.miss, bus.valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL miss_after_%0d: miss/vld got %b/%b required 0/0", i, bus.miss, bus.valid);
            end
        end
    endtask

    task automatic test_backpressure();
        bus.matched = 16'h8001; bus.match_valid = 1'b1; bus.ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.match_valid = 1'b0;
            n_cmp++;
            if ({bus.valid, bus.address, bus.last, bus.count} !== {1'b1, 4'd0, 1'b0, 5'd2}) begin
                n_fail++;
                $display("FAIL stall_%0d: vld/addr/last/cnt got %b/%0d/%b/%0d required 1/0/0/2",
                         i, bus.valid, bus.address, bus.last, bus.count);
            end
            $display("stall cycle %0d: address=%0d valid=%b", i, bus.address, bus.valid);
        end
        bus.ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.valid, bus.address, bus.last} !== {1'b1, 4'd15, 1'b1}) begin
            n_fail++;
            $display("FAIL stall_release: vld/addr/last got %b/%0d/%b required 1/15/1", bus.valid, bus.address, bus.last);
        end
        $display("stall release beat: address=%0d last=%b", bus.address, bus.last);
        @(negedge clk);
        n_cmp++;
        if ({bus.valid, bus.match_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL stall_done: vld/rdy got %b/%b required 0/1", bus.valid, bus.match_ready);
        end
    endtask

    task automatic test_ignore_busy();
        bus.matched = 16'h0006; bus.match_valid = 1'b1; bus.ready = 1'b1;
        @(negedge clk);
        bus.matched = 16'h0100;
        n_cmp++;
        if ({bus.valid, bus.address, bus.last, bus.match_ready} !== {1'b1, 4'd1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ignore_first: vld/addr/last/rdy got %b/%0d/%b/%b required 1/1/0/0",
                     bus.valid, bus.address, bus.last, bus.match_ready);
        end
        $display("ignore_busy beat: address=%0d last=%b", bus.address, bus.last);
        @(negedge clk);
        bus.match_valid = 1'b0;
        n_cmp++;
        if ({bus.valid, bus.address, bus.last, bus.count} !== {1'b1, 4'd2, 1'b1, 5'd2}) begin
            n_fail++;
            $display("FAIL ignore_second: vld/addr/last/cnt got %b/%0d/%b/%0d required 1/2/1/2",
                     bus.valid, bus.address, bus.last, bus.count);
        end
        $display("ignore_busy beat: address=%0d last=%b", bus.address, bus.last);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.valid, bus.match_ready, bus.count} !== {1'b0, 1'b1, 5'd2}) begin
                n_fail++;
                $display("FAIL ignore_after_%0d: vld/rdy/cnt got %b/%b/%0d required 0/1/2",
                         i, bus.valid, bus.match_ready, bus.count);
            end
        end
    endtask

    task automatic test_full();
        bus.matched = 16'hFFFF; bus.match_valid = 1'b1; bus.ready = 1'b1;
        @(negedge clk);
        bus.match_valid = 1'b0;
        n_cmp++;
        if (bus.count !== 5'd16) begin
            n_fail++;
            $display("FAIL full_count: got %0d required 16", bus.count);
        end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if ({bus.valid, bus.address, bus.last} !== {1'b1, 4'(i), (i == 15)}) begin
                n_fail++;
                $display("FAIL full_beat_%0d: vld/addr/last got %b/%0d/%b required 1/%0d/%b",
                         i, bus.valid, bus.address, bus.last, i, (i == 15));
            end
            $display("full beat: address=%0d last=%b", bus.address, bus.last);
            @(negedge clk);
        end
        n_cmp++;
        if ({bus.valid, bus.match_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL full_done: vld/rdy got %b/%b required 0/1", bus.valid, bus.match_ready);
        end
    endtask

    task automatic test_reset_mid_busy();
        bus.matched = 16'hFFFF; bus.match_valid = 1'b1; bus.ready = 1'b1;
        @(negedge clk);
        bus.match_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.valid, bus.address} !== {1'b1, 4'd3}) begin
            n_fail++;
            $display("FAIL midreset_pre: vld/addr got %b/%0d required 1/3", bus.valid, bus.address);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({bus.valid, bus.count, bus.match_ready, bus.miss, bus.address, bus.last} !==
            {1'b0, 5'd0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_post: vld/cnt/rdy/miss/addr/last got %b/%0d/%b/%b/%0d/%b required 0/0/1/0/0/0",
                     bus.valid, bus.count, bus.match_ready, bus.miss, bus.address, bus.last);
        end
        $display("reset mid-busy: valid=%b count=%0d match_ready=%b", bus.valid, bus.count, bus.match_ready);
    endtask

    initial begin
        test_reset();
        test_two_match();
        test_miss();
        test_backpressure();
        test_ignore_busy();
        test_full();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
